// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one 64-bit memory port
// between requester A (instruction fetch) and requester B (load/store).
//
// Ports:
//   clk, reset               clock (rising edge), synchronous active-high reset
//   req_x/addr_x/wdata_x/we_x requester x transfer request and payload (x = a, b)
//   gnt_x                    combinational: request x accepted this cycle
//   done_x, err_x            registered one-cycle completion pulse / timeout flag
//   rdata                    read data, valid while done_a or done_b is high
//   mem_req/addr/wdata/we    latched memory request towards the shared port
//   mem_sel                  owner of the port (0 = A, 1 = B), drives the data mux
//   mem_ready, mem_rdata     memory completion and read data
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [63:0] addr_a,
    input  logic [63:0] wdata_a,
    input  logic        we_a,
    output logic        gnt_a,
    output logic        done_a,
    output logic        err_a,
    input  logic        req_b,
    input  logic [63:0] addr_b,
    input  logic [63:0] wdata_b,
    input  logic        we_b,
    output logic        gnt_b,
    output logic        done_b,
    output logic        err_b,
    output logic [63:0] rdata,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_sel,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata
);

    // Counter value on the last BUSY cycle allowed before the abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic             last_b;   // 1 when B was granted most recently
    logic [CNT_W-1:0] cnt;

    // Grants only while idle; on a tie the requester not served last wins.
    assign gnt_a = (state == IDLE) && req_a && (!req_b || last_b);
    assign gnt_b = (state == IDLE) && req_b && (!req_a || !last_b);

    // Arbitration and memory handshake sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
            rdata     <= '0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            err_a  <= 1'b0;
            err_b  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_a || gnt_b) begin
                        mem_addr  <= gnt_b ? addr_b  : addr_a;
                        mem_wdata <= gnt_b ? wdata_b : wdata_a;
                        mem_we    <= gnt_b ? we_b    : we_a;
                        mem_sel   <= gnt_b;
                        last_b    <= gnt_b;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // mem_ready takes priority over a coinciding timeout.
                    if (mem_ready) begin
                        rdata   <= mem_rdata;
                        done_a  <= !mem_sel;
                        done_b  <= mem_sel;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        rdata   <= '0;
                        done_a  <= !mem_sel;
                        done_b  <= mem_sel;
                        err_a   <= !mem_sel;
                        err_b   <= mem_sel;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model schedules
// grants, memory latency and completions; a negedge monitor checks the DUT.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        logic        owner;
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } done_t;

    logic        clk;
    logic        reset;
    logic        req_a, we_a, gnt_a, done_a, err_a;
    logic        req_b, we_b, gnt_b, done_b, err_b;
    logic [63:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_sel, mem_ready;

    mem_port_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
        .gnt_a(gnt_a), .done_a(done_a), .err_a(err_a),
        .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
        .gnt_b(gnt_b), .done_b(done_b), .err_b(err_b),
        .rdata(rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard and model state
    req_t        qa[$], qb[$], memq[$];
    done_t       doneq[$];
    int          wq[$];
    logic [63:0] rdq[$];
    req_t        pa, pb, cur;
    done_t       d;
    bit          hold_a, hold_b, rel_a, rel_b;
    bit          last_b = 1'b1;
    bit          sel_now, sel_next;
    int          busy_lo = 1, busy_hi = 0, c_last = 0, ready_cyc = -1;
    logic [63:0] rd_val;
    bit          exp_gnt_a, exp_gnt_b, exp_mem_req, exp_rst;
    bit          rst_req, rand_rst, chk, first_chk = 1'b1, mem_req_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.addr  = {$urandom, $urandom};
        r.wdata = {$urandom, $urandom};
        r.we    = 1'($urandom);
        return r;
    endfunction

    // One clock of stimulus plus the reference model's decisions for it.
    task automatic step();
        int          t;
        int          w;
        bit          do_rst, ga, gb;
        logic [63:0] rd;
        req_t        p;
        @(posedge clk);
        #1;
        t = cyc;
        sel_now = sel_next;
        if (rel_a) hold_a = 1'b0;
        if (rel_b) hold_b = 1'b0;
        if (!hold_a && qa.size() > 0) begin pa = qa.pop_front(); hold_a = 1'b1; end
        if (!hold_b && qb.size() > 0) begin pb = qb.pop_front(); hold_b = 1'b1; end
        do_rst = rst_req || (rand_rst && t >= busy_lo && t <= busy_hi
                             && $urandom_range(0, 149) == 0);
        reset   = do_rst;
        req_a   = hold_a;
        addr_a  = hold_a ? pa.addr  : {$urandom, $urandom};
        wdata_a = hold_a ? pa.wdata : {$urandom, $urandom};
        we_a    = hold_a ? pa.we    : 1'($urandom);
        req_b   = hold_b;
        addr_b  = hold_b ? pb.addr  : {$urandom, $urandom};
        wdata_b = hold_b ? pb.wdata : {$urandom, $urandom};
        we_b    = hold_b ? pb.we    : 1'($urandom);
        ga = 1'b0;
        gb = 1'b0;
        if (do_rst) begin
            // Outstanding transfer is abandoned; port is free next cycle.
            while (doneq.size() > 0 && doneq[$].cyc > t) void'(doneq.pop_back());
            if (busy_hi > t) busy_hi = t;
            c_last    = t + 1;
            last_b    = 1'b1;
            ready_cyc = -1;
            sel_next  = 1'b0;
        end else begin
            chk = 1'b1;
            if (t >= c_last && (hold_a || hold_b)) begin
                gb = hold_b && (!hold_a || !last_b);
                ga = !gb;
                p  = gb ? pb : pa;
                w  = (wq.size() > 0) ? wq.pop_front() : int'($urandom_range(0, TMO));
                rd = (rdq.size() > 0) ? rdq.pop_front() : {$urandom, $urandom};
                last_b    = gb;
                sel_next  = gb;
                busy_lo   = t + 1;
                busy_hi   = t + ((w < TMO) ? w + 1 : TMO);
                c_last    = busy_hi + 1;
                ready_cyc = (w < TMO) ? t + 1 + w : -1;
                rd_val    = rd;
                memq.push_back(p);
                doneq.push_back('{gb, (w >= TMO), (w >= TMO) ? 64'h0 : rd, c_last});
            end
        end
        exp_gnt_a   = ga;
        exp_gnt_b   = gb;
        exp_rst     = do_rst;
        exp_mem_req = (t >= busy_lo && t <= busy_hi);
        mem_ready   = (t == ready_cyc);
        mem_rdata   = mem_ready ? rd_val : {$urandom, $urandom};
        rel_a = ga;
        rel_b = gb;
    endtask

    // Monitor: compares DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (chk) begin
            if (first_chk) begin
                check("rst_rdata", rdata, 64'h0);
                check("rst_mem_addr", mem_addr, 64'h0);
                check("rst_mem_wdata", mem_wdata, 64'h0);
                check("rst_mem_we", mem_we, 1'b0);
                first_chk = 1'b0;
            end
            if (!exp_rst) begin
                check("gnt_a", gnt_a, exp_gnt_a);
                check("gnt_b", gnt_b, exp_gnt_b);
            end
            check("mem_req", mem_req, exp_mem_req);
            check("mem_sel", mem_sel, sel_now);
            if (mem_req && !mem_req_q && memq.size() > 0) begin
                cur = memq.pop_front();
                check("mem_addr", mem_addr, cur.addr);
                check("mem_wdata", mem_wdata, cur.wdata);
                check("mem_we", mem_we, cur.we);
            end else if (mem_req) begin
                check("mem_addr_hold", mem_addr, cur.addr);
                check("mem_wdata_hold", mem_wdata, cur.wdata);
                check("mem_we_hold", mem_we, cur.we);
            end
            check("done_excl", done_a & done_b, 1'b0);
            check("err_a_stray", err_a & !done_a, 1'b0);
            check("err_b_stray", err_b & !done_b, 1'b0);
            if (done_a || done_b) begin
                check("done_expected", 64'(doneq.size() > 0), 64'h1);
                if (doneq.size() > 0) begin
                    d = doneq.pop_front();
                    check("done_owner", done_b, d.owner);
                    check("done_err", done_b ? err_b : err_a, d.err);
                    check("done_rdata", rdata, d.rdata);
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                end
            end else if (doneq.size() > 0 && doneq[0].cyc <= cyc) begin
                check("done_seen", done_a | done_b, 1'b1);
                void'(doneq.pop_front());
            end
        end
        mem_req_q = mem_req;
    end

    initial begin
        reset = 1'b1;
        req_a = 1'b0; addr_a = '0; wdata_a = '0; we_a = 1'b0;
        req_b = 1'b0; addr_b = '0; wdata_b = '0; we_b = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;

        // Single read from A, memory answers one cycle after mem_req rises
        qa.push_back('{64'h1000, 64'h0, 1'b0});
        wq.push_back(1);
        rdq.push_back(64'hDEADBEEF);
        repeat (6) step();

        // Both request right after reset: A,B,A,B
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        qa.push_back(rnd_req()); qa.push_back(rnd_req());
        qb.push_back(rnd_req()); qb.push_back(rnd_req());
        wq.push_back(0); wq.push_back(2); wq.push_back(1); wq.push_back(0);
        repeat (20) step();

        // B write with three wait cycles
        qb.push_back('{64'h2008, 64'h55, 1'b1});
        wq.push_back(3);
        repeat (8) step();

        // Timeout, then mem_ready coinciding with the timeout cycle
        qa.push_back(rnd_req()); qa.push_back(rnd_req());
        wq.push_back(TMO); wq.push_back(TMO - 1);
        repeat (16) step();

        // Reset during BUSY with B waiting behind A
        qa.push_back(rnd_req());
        wq.push_back(TMO);
        step();
        step();
        qb.push_back(rnd_req());
        step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        repeat (10) step();

        // Random traffic with occasional reset mid-transfer
        rand_rst = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (qa.size() < 2 && $urandom_range(0, 3) == 0) qa.push_back(rnd_req());
            if (qb.size() < 2 && $urandom_range(0, 3) == 0) qb.push_back(rnd_req());
            step();
        end
        rand_rst = 1'b0;
        repeat (40) step();
        @(negedge clk);
        check("doneq_empty", 64'(doneq.size()), 64'h0);
        check("memq_empty", 64'(memq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit memory port between two requesters: A is instruction fetch, B is load/store.
- It grants one requester at a time and captures that requester's address, write data and write enable.
- It drives the existing 64-bit 2:1 select mux through mem_sel, sequences the memory handshake, and returns read data with a per-requester completion pulse.
- It sits between the fetch/LSU stages and the shared memory.

Parameters:
- TIMEOUT, 16: number of BUSY cycles allowed without mem_ready before the transfer is aborted. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  requester A wants a transfer; held with its payload until gnt_a.
- addr_a  in  64  requester A address.
- wdata_a  in  64  requester A write data.
- we_a  in  1  requester A write enable.
- gnt_a  out  1  combinational; A's request is accepted in this cycle.
- done_a  out  1  one-cycle pulse; A's transfer has completed.
- err_a  out  1  valid with done_a; A's transfer timed out.
- req_b, addr_b, wdata_b, we_b, gnt_b, done_b, err_b: same as the A ports, for requester B.
- rdata  out  64  read data; valid while done_a or done_b is high.
- mem_req  out  1  memory request; held high until mem_ready or timeout.
- mem_addr  out  64  latched address.
- mem_wdata  out  64  latched write data.
- mem_we  out  1  latched write enable.
- mem_sel  out  1  owner of the port, 0=A 1=B; drives the datapath mux select.
- mem_ready  in  1  memory has completed the request this cycle.
- mem_rdata  in  64  memory read data, valid with mem_ready.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_sel=0.
  - done_a=0, done_b=0, err_a=0, err_b=0, rdata=0.
  - last_served=B, so A wins the first tie.
  - timeout counter=0.
- Reset mid-transfer: the transfer is abandoned with no done pulse; mem_req drops on the next edge.
- State IDLE:
  - gnt_x is combinational and asserts only in IDLE.
  - If exactly one req_x is high, gnt_x=1.
  - If both are high, grant the requester that is not last_served.
  - On grant: latch addr/wdata/we from the granted requester into the mem_* registers, set mem_sel=owner, set mem_req=1, update last_served, clear the counter, go to BUSY.
  - If no req_x is high, stay in IDLE.
- State BUSY:
  - mem_* outputs are held stable and gnt_a=gnt_b=0.
  - If mem_ready=1: capture rdata=mem_rdata, pulse done_owner=1 and err_owner=0 in the next cycle, set mem_req=0, go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: pulse done_owner=1 and err_owner=1 in the next cycle, set rdata=0, set mem_req=0, go to IDLE.
  - Else counter+1.
  - If mem_ready and the timeout fall in the same cycle, mem_ready wins (err=0).
- Write transfers: rdata = whatever mem_rdata holds when mem_ready is sampled; requesters ignore it.
- Latency and throughput:
  - req_x high in cycle 0 while IDLE: gnt_x in cycle 0, mem_req high from cycle 1.
  - mem_ready sampled in cycle k gives done_x in cycle k+1.
  - The arbiter is back in IDLE in cycle k+1 and can issue a new grant in that same cycle.
  - Best case is one transfer per 2 cycles.
- Output timing: done_x and err_x are registered single-cycle pulses. done_a and done_b are never high together.
- mem_sel holds the last owner while IDLE. It changes only on a grant.
- Fairness: when both requesters are continuously requesting, grants strictly alternate A,B,A,B.

Test Plan:
- Reset, then req_a=1 with addr_a=0x1000 and we_a=0 -> gnt_a in the same cycle; next cycle mem_req=1, mem_addr=0x1000, mem_sel=0. Memory raises mem_ready one cycle later with mem_rdata=0xDEADBEEF -> done_a pulse with rdata=0xDEADBEEF, err_a=0.
- req_a and req_b both high in the first cycle after reset -> A granted first, then B granted in the cycle done_a pulses. Held continuously for 4 grants -> grant order A,B,A,B.
- B write with addr_b=0x2008, wdata_b=0x55, we_b=1 -> mem_we=1, mem_wdata=0x55, mem_sel=1 throughout BUSY; memory ready after 3 wait cycles -> done_b, err_b=0.
- TIMEOUT=4 and mem_ready never asserted -> mem_req high for exactly 4 cycles, then done pulse with err=1 and rdata=0. Then mem_ready and the timeout coinciding -> err=0 and rdata=mem_rdata.
- Assert reset during BUSY -> next cycle mem_req=0 and state IDLE, no done pulse; a pending req_b is granted after reset deasserts.
- req_b raised while A is in BUSY -> gnt_b=0 and mem_* unchanged until done_a; gnt_b then asserts in the done_a cycle.
